tap_accumulator: RTL and testbench

Sequential accumulation stage wrapped around the 32-bit combinational `adder` in the filter datapath. It feeds the adder's `opA`/`opB` and registers its `sum` once per accepted input beat. It sums a programmed number of filter-tap products arriving on a valid/ready stream and presents the final total on an output valid/ready port.

---
 rtl/tap_accumulator.sv | 128 ++++++++++++
 tb/tb_tap_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_accumulator.sv
// Accumulation stage around the external 32-bit adder: sums num_taps signed beats, then presents the total.
// Optional build macro TAP_ACC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module tap_accumulator #(
  parameter int DATA_W = 32,
  parameter int TAPS_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TAPS_W-1:0] num_taps,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_sum,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_nxt;
  logic [TAPS_W-1:0]   cnt;
  logic [TAPS_W-1:0]   taps;
  logic                ovf_q;
  logic                start_acc;
  logic                fire;
  logic                last_beat;
  logic                beat_ovf;

  assign add_a    = acc;
  assign add_b    = in_data;
  assign out_data = acc;
  assign ovf      = ovf_q;

  assign start_acc = (state == IDLE) && start;
  assign fire      = in_valid && in_ready;
  assign last_beat = (cnt == taps - TAPS_W'(1));

  // Same-sign operands producing a result of the other sign is a two's complement overflow.
  assign beat_ovf = (acc[DATA_W-1] == in_data[DATA_W-1]) &&
                    (add_sum[DATA_W-1] != acc[DATA_W-1]);

`ifdef TAP_ACC_SAT_EN
  always_comb begin
    acc_nxt = add_sum;
    if (beat_ovf) begin
      acc_nxt = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign acc_nxt = add_sum;
`endif

  // NOTE: registers are written with <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (num_taps == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      taps  <= '0;
      ovf_q <= 1'b0;
    end else if (start_acc) begin
      acc   <= '0;
      cnt   <= '0;
      taps  <= num_taps;
      ovf_q <= 1'b0;
    end else if (fire) begin
      acc <= acc_nxt;
      // Hold the count on the final beat so it never passes taps - 1.
      if (!last_beat) begin
        cnt <= cnt + TAPS_W'(1);
      end
      if (beat_ovf) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tap_accumulator.sv
// Self-checking bench for tap_accumulator: directed vector table, reset abort sequence, and
// randomized jobs scored against an integer-arithmetic model (honours TAP_ACC_SAT_EN).
module tb_tap_accumulator;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] num_taps = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_sum;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] beats_q[$];

  // The external combinational adder this stage drives.
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  tap_accumulator #(.DATA_W(DW), .TAPS_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_taps  (num_taps),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sum beats_q[0..n-1] with wide integers; overflow means leaving the 32-bit signed range.
  task automatic model(input int n, output logic [DW-1:0] d, output logic o);
    longint acc;
    longint s;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + longint'($signed(beats_q[i]));
      if (s > SMAX || s < SMIN) begin
        o = 1'b1;
`ifdef TAP_ACC_SAT_EN
        acc = (s > SMAX) ? SMAX : SMIN;
`else
        acc = longint'($signed(s[31:0]));
`endif
      end else begin
        acc = s;
      end
    end
    d = acc[31:0];
  endtask

  // One complete job, starting and ending at a falling edge with the DUT idle.
  // gap_mode: 0 none, 1 gaps of 1..3 cycles, 2 random gaps of 0..2 cycles.
  task automatic run_job(input int n, input int gap_mode, input int hold,
                         input logic [DW-1:0] exp_d, input logic exp_o, input string tag);
    int g;
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle in_ready"}, in_ready, 0);
    start    = 1'b1;
    num_taps = n[TW-1:0];
    @(negedge clk);
    start    = 1'b0;
    num_taps = TW'($urandom);
    check({tag, " busy after start"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      g = (gap_mode == 1) ? (i % 3) + 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        check({tag, " busy in gap"}, busy, 1);
      end
      in_valid = 1'b1;
      in_data  = beats_q[i];
      check({tag, " in_ready"}, in_ready, 1);
      check({tag, " early out_valid"}, out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_data"}, out_data, exp_d);
    check({tag, " ovf"}, ovf, exp_o);
    for (int h = 0; h < hold; h++) begin
      start    = 1'b1;
      num_taps = TW'(3);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held out_data"}, out_data, exp_d);
      check({tag, " held in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    num_taps  = TW'(3);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    check({tag, " busy after handshake"}, busy, 0);
  endtask

  typedef struct {
    int                 n;
    logic [DW-1:0]      b0, b1, b2, b3;
    int                 gap_mode;
    int                 hold;
    logic [DW-1:0]      exp_d;
    logic               exp_o;
    string              tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] d;
    logic          o;
    int            n;
    int            r;

`ifdef TAP_ACC_SAT_EN
    vecs[2] = '{2, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 0, 0, 32'h7FFFFFFF, 1'b1, "pos_ovf"};
    vecs[3] = '{2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1, 32'h80000000, 1'b1, "neg_ovf"};
`else
    vecs[2] = '{2, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 0, 0, 32'h80000000, 1'b1, "pos_ovf"};
    vecs[3] = '{2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1, 32'h7FFFFFFF, 1'b1, "neg_ovf"};
`endif
    vecs[0] = '{3, 32'd2, 32'd4, 32'd6, 32'h0, 0, 0, 32'h0000000C, 1'b0, "basic"};
    vecs[1] = '{2, 32'hFFFFFFFE, 32'd5, 32'h0, 32'h0, 0, 0, 32'd3, 1'b0, "signed"};
    vecs[4] = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5, 32'h0, 1'b0, "zero_taps"};
    vecs[5] = '{4, 32'd1, 32'd2, 32'd3, 32'd4, 1, 0, 32'd10, 1'b0, "gapped"};

    @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    check("reset add_a", add_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      beats_q = '{vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
      run_job(vecs[v].n, vecs[v].gap_mode, vecs[v].hold, vecs[v].exp_d, vecs[v].exp_o, vecs[v].tag);
    end

    // Abort after two of four beats, then confirm no residue.
    start    = 1'b1;
    num_taps = TW'(4);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd5;
    @(negedge clk);
    in_data  = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort partial add_a", add_a, 32'd11);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort out_data", out_data, 0);
    check("abort busy", busy, 0);
    check("abort ovf", ovf, 0);
    check("abort add_a", add_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beats_q = '{32'd7, 32'd8};
    run_job(2, 0, 0, 32'd15, 1'b0, "after_abort");

    for (int j = 0; j < 40; j++) begin
      n = (j == 0) ? 31 : int'($urandom_range(0, 8));
      beats_q.delete();
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(0, 3));
        beats_q.push_back((r == 0) ? 32'h7FFFFFF0 + $urandom_range(0, 31) :
                          (r == 1) ? 32'h80000000 + $urandom_range(0, 31) : $urandom);
      end
      model(n, d, o);
      run_job(n, 2, int'($urandom_range(0, 2)), d, o, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
